// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: controller and arbiter for the single-port 32x5 LED sequence RAM.
// Three requesters share the one RAM port: a user write port, a bulk clear
// engine and a tick-paced playback reader that latches each word onto the LEDs.
// Arbitration in IDLE is fixed priority: clear > user write > playback tick.
//
// Ports:
//   clk, rst              system clock; asynchronous active-high reset
//   wr_req/wr_addr/wr_data user write request (held until wr_ack) and payload
//   wr_ack                one-cycle pulse during the RAM write cycle
//   clr_req               request to zero every RAM word
//   play_en               playback enable
//   busy                  high whenever the FSM is not in IDLE
//   play_addr             address of the next word to play
//   led_out               last word played
//   ram_addr/ram_data     RAM address and write data
//   ram_wren/ram_rden     RAM write / read strobes
//   ram_q                 RAM read data, valid the cycle after ram_rden
module ram_seq_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 5,
  parameter int TICK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_req,
  input  logic              play_en,
  output logic              busy,
  output logic [ADDR_W-1:0] play_addr,
  output logic [DATA_W-1:0] led_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [TW-1:0]     TICK_MAX  = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, CLEAR} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] play_addr_q;
  logic [DATA_W-1:0] led_out_q;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick_pend_q;
  logic              tick_wrap;
  logic              wr_ack_q, busy_q, ram_wren_q, ram_rden_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;

  always_comb begin
    tick_wrap  = play_en && (tick_cnt_q == TICK_MAX);
    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);
  end

  // Tick generator: a wrap while a tick is already pending is simply dropped.
  // A wrap on the READ_WAIT cycle re-arms the pending flag instead of clearing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
    end else if (!play_en) begin
      tick_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      if (tick_wrap)
        tick_pend_q <= 1'b1;
      else if (state_q == READ_WAIT)
        tick_pend_q <= 1'b0;
    end
  end

  // RAM strobes are loaded together with the state they belong to, so every
  // ram_* output is a flop and the user write payload is captured in
  // ram_addr_q / ram_data_q on the IDLE->WRITE transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      play_addr_q <= '0;
      led_out_q   <= '0;
      wr_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      ram_wren_q  <= 1'b0;
      ram_rden_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      wr_ack_q   <= 1'b0;
      ram_wren_q <= 1'b0;
      ram_rden_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            ram_wren_q <= 1'b1;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            busy_q     <= 1'b1;
          end else if (wr_req) begin
            state_q    <= WRITE;
            ram_wren_q <= 1'b1;
            ram_addr_q <= wr_addr;
            ram_data_q <= wr_data;
            wr_ack_q   <= 1'b1;
            busy_q     <= 1'b1;
          end else if (play_en && tick_pend_q) begin
            state_q    <= READ;
            ram_rden_q <= 1'b1;
            ram_addr_q <= play_addr_q;
            busy_q     <= 1'b1;
          end
        end
        WRITE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        READ: begin
          state_q <= READ_WAIT;
        end
        READ_WAIT: begin
          led_out_q   <= ram_q;
          play_addr_q <= play_addr_q + 1'b1;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
        end
        CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            led_out_q   <= '0;
            play_addr_q <= '0;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end else begin
            clr_cnt_q  <= clr_cnt_q + 1'b1;
            ram_wren_q <= 1'b1;
            ram_addr_q <= clr_cnt_q + 1'b1;
            ram_data_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ack    = wr_ack_q;
  assign busy      = busy_q;
  assign play_addr = play_addr_q;
  assign led_out   = led_out_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign ram_wren  = ram_wren_q;
  assign ram_rden  = ram_rden_q;

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
- Controller and arbiter for the single-port 32x5 sequence RAM that drives the board LEDs.
- Shares the one RAM port between three requesters:
  - a user write port (switch/key data);
  - a bulk clear engine;
  - a tick-paced playback reader that steps through all 32 words and latches each onto the LEDs.
- Sits between board I/O debounce logic and the RAM macro; the controller is the only master of the RAM.

Parameters:
- ADDR_W, 5, RAM address width (depth = 2**ADDR_W = 32 words).
- DATA_W, 5, RAM word width.
- TICK_DIV, 25000000, clk cycles per playback step (minimum 4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_req  input  1  user write request; held high until wr_ack.
- wr_addr  input  ADDR_W  user write address, sampled with wr_req in IDLE.
- wr_data  input  DATA_W  user write data, sampled with wr_req in IDLE.
- wr_ack  output  1  one-cycle pulse, high during the RAM write cycle.
- clr_req  input  1  request to zero all 32 words (level or pulse; sampled in IDLE).
- play_en  input  1  playback enable.
- busy  output  1  high whenever the FSM is not in IDLE.
- play_addr  output  ADDR_W  address of the next word to play.
- led_out  output  DATA_W  last word played, registered.
- ram_addr  output  ADDR_W  RAM address.
- ram_data  output  DATA_W  RAM write data.
- ram_wren  output  1  RAM write enable.
- ram_rden  output  1  RAM read enable.
- ram_q  input  DATA_W  RAM read data, valid the cycle after ram_rden is high.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; led_out, play_addr, clr_cnt, tick_cnt, tick_pend = 0.
  - wr_ack, busy, ram_wren, ram_rden = 0.
  - ram_addr and ram_data = 0.
  - An in-flight write or clear is abandoned with no further RAM strobes.
- RAM outputs decode from the state and internal registers only. There is no combinational path from any input to any ram_* output.
- Tick generator:
  - When play_en = 1, tick_cnt counts 0..TICK_DIV-1 and wraps.
  - On the wrap cycle, tick_pend is set to 1.
  - When play_en = 0, tick_cnt and tick_pend are held at 0.
  - A tick that arrives while tick_pend is already 1 is dropped; no accumulation.
- FSM states: IDLE, WRITE, READ, READ_WAIT, CLEAR. Arbitration in IDLE uses fixed priority clr_req > wr_req > (play_en & tick_pend).
- IDLE:
  - All strobes are low.
  - On clr_req: clr_cnt = 0, go to CLEAR.
  - Else on wr_req: capture wr_addr and wr_data, go to WRITE.
  - Else on play_en & tick_pend: go to READ.
- WRITE (1 cycle):
  - ram_wren = 1, ram_addr = captured address, ram_data = captured data, wr_ack = 1.
  - Next state IDLE.
  - The requester drops wr_req after seeing wr_ack. If wr_req is still high in IDLE, it is treated as a new request.
- READ (1 cycle): ram_rden = 1, ram_addr = play_addr. Next state READ_WAIT.
- READ_WAIT (1 cycle):
  - led_out <= ram_q.
  - play_addr <= play_addr + 1, modulo 32 (31 wraps to 0).
  - tick_pend <= 0, unless a new tick sets it on this same cycle; set wins.
  - Next state IDLE.
- CLEAR (32 cycles):
  - ram_wren = 1, ram_addr = clr_cnt, ram_data = 0; clr_cnt increments each cycle.
  - On the clr_cnt = 31 cycle: led_out <= 0, play_addr <= 0, go to IDLE.
  - clr_req and wr_req are ignored while in CLEAR. A wr_req still held waits and is serviced afterwards.
- Latency:
  - User write: wr_ack arrives 1 cycle after wr_req is sampled in IDLE, if no clear is pending.
  - Playback: led_out updates 3 cycles after tick_pend rises, if not blocked.
- Simultaneous events:
  - A write request and a playback tick in the same IDLE cycle: the write wins and tick_pend stays set. The read follows 2 cycles later.
  - play_en falling during READ or READ_WAIT: the read completes and led_out still updates.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset check: apply rst mid-CLEAR (clr_cnt = 10) -> all outputs 0 that same cycle; after release, state IDLE and no ram_wren.
- Single write: wr_req with addr 5, data 0x1A -> next cycle ram_wren = 1, ram_addr = 5, ram_data = 0x1A, wr_ack = 1; RAM model holds 0x1A at word 5.
- Playback (TICK_DIV = 4; RAM preloaded word n = n):
  - play_en = 1 -> led_out steps 0,1,2,... every 4 cycles;
  - after word 31, play_addr wraps to 0 and led_out = 0 on the next step.
- Arbitration: wr_req asserted on the exact cycle tick_pend is set -> WRITE occurs first, then READ 2 cycles later; no tick is lost.
- Clear:
  - clr_req -> exactly 32 consecutive ram_wren cycles on addresses 0..31 with data 0;
  - then led_out = 0, play_addr = 0;
  - a wr_req raised mid-clear is acked only after the clear completes.
- Disable: play_en dropped for 10 cycles then raised -> no reads during the gap; the first read comes TICK_DIV cycles after re-enable.
